// File: rtl/counter_seg_scan.sv
// counter_seg_scan
//   Multi-digit hex up/down counter with a time-multiplexed seven-segment
//   display driver. A prescaler turns clock cycles into count ticks. A free
//   running scan timer walks a digit index, and the nibble at that index is
//   decoded onto one shared active-low segment bus.
//
//   Optional feature: define COUNTER_SEG_BLANK_EN to build leading-zero
//   blanking. Digit 0 is never blanked.
//
// Parameters
//   DIGITS    number of hex digits, W = 4*DIGITS (>= 1)
//   CLK_DIV   clock cycles per count tick (>= 1)
//   SCAN_DIV  clock cycles per digit scan step (>= 1)
//
// Ports
//   i_clk       clock
//   i_rst       synchronous reset, active-high; overrides every other input
//   i_en        count enable; the prescaler holds while low
//   i_up        count direction (1 = up), sampled on the tick cycle
//   i_clr       synchronous clear of the count and the prescaler
//   i_load      synchronous load of i_load_val; also clears the prescaler
//   i_load_val  load value [W-1:0]
//   o_cnt       current count [W-1:0]
//   o_wrap      one-cycle pulse after a tick that wraps the count
//   o_seg       segments {a,b,c,d,e,f,g}, active-low
//   o_an        digit select, active-low one-hot [DIGITS-1:0]
module counter_seg_scan #(
  parameter int DIGITS   = 4,
  parameter int CLK_DIV  = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_up,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_cnt,
  output logic                  o_wrap,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_an
);
  localparam int W  = 4*DIGITS;
  localparam int PW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  logic [W-1:0]      r_cnt;
  logic              r_wrap;
  logic [PW-1:0]     r_pre;
  logic [SW-1:0]     r_scan;
  logic [IW-1:0]     r_idx;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;

  logic              w_tick;
  logic [3:0]        w_nib;
  logic [6:0]        w_seg;

  function automatic logic [6:0] f_dec(input logic [3:0] n);
    case (n)
      4'h0: f_dec = 7'b0000001;
      4'h1: f_dec = 7'b1001111;
      4'h2: f_dec = 7'b0010010;
      4'h3: f_dec = 7'b0000110;
      4'h4: f_dec = 7'b1001100;
      4'h5: f_dec = 7'b0100100;
      4'h6: f_dec = 7'b0100000;
      4'h7: f_dec = 7'b0001111;
      4'h8: f_dec = 7'b0000000;
      4'h9: f_dec = 7'b0000100;
      4'hA: f_dec = 7'b0001000;
      4'hB: f_dec = 7'b1100000;
      4'hC: f_dec = 7'b0110001;
      4'hD: f_dec = 7'b1000010;
      4'hE: f_dec = 7'b0110000;
      default: f_dec = 7'b0111000;
    endcase
  endfunction

  assign w_tick = i_en && (r_pre == PW'(CLK_DIV-1));

  // Count path: clear > load > tick. Clear/load kill a coincident tick and
  // its wrap pulse because they take the branch before the tick is looked at.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_pre  <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_pre  <= '0;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_wrap <= 1'b0;
      r_pre  <= '0;
    end else begin
      if (i_en) r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_cnt  <= i_up ? r_cnt + 1'b1 : r_cnt - 1'b1;
        r_wrap <= i_up ? (r_cnt == {W{1'b1}}) : (r_cnt == '0);
      end else begin
        r_wrap <= 1'b0;
      end
    end
  end

  // Nibble select and decode for the digit currently addressed by r_idx.
  always_comb begin
    w_nib = '0;
    for (int k = 0; k < DIGITS; k++)
      if (r_idx == IW'(k)) w_nib = r_cnt[4*k +: 4];
  end

`ifdef COUNTER_SEG_BLANK_EN
  logic w_blank;
  logic w_zero;
  // Walk from the top digit down; w_zero stays set while every nibble from
  // the top through digit k is zero, which is exactly the blank condition.
  always_comb begin
    w_blank = 1'b0;
    w_zero  = 1'b1;
    for (int k = DIGITS-1; k > 0; k--) begin
      w_zero = w_zero & (r_cnt[4*k +: 4] == 4'h0);
      if (r_idx == IW'(k)) w_blank = w_zero;
    end
    w_seg = w_blank ? 7'b1111111 : f_dec(w_nib);
  end
`else
  assign w_seg = f_dec(w_nib);
`endif

  // Scan path runs regardless of enable/clear/load. o_an and o_seg are both
  // derived from the same r_idx in the same cycle so they never disagree.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_seg  <= 7'b1111111;
      r_an   <= '1;
    end else begin
      if (r_scan == SW'(SCAN_DIV-1)) begin
        r_scan <= '0;
        r_idx  <= (r_idx == IW'(DIGITS-1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_seg <= w_seg;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = r_wrap;
  assign o_seg  = r_seg;
  assign o_an   = r_an;
endmodule
